// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared OFDM constants, sample widths and subcarrier map helper
//
// Purpose: default symbol geometry (FFT size, active band edges, pilot spacing),
//          sample field widths and the subcarrier classifier. Shared by the receive
//          pilot-remove block and the transmit pilot-insert block so both sides
//          always agree on which subcarriers carry data.
// Ports:   none (package).
package ofdm_pkg;

   localparam int NSC_DEF = 256;   // subcarriers per OFDM symbol
   localparam int GLO_DEF = 28;    // first active subcarrier
   localparam int GHI_DEF = 228;   // last active subcarrier
   localparam int PSP_DEF = 8;     // pilot spacing from GLO

   localparam int IQ_W  = 16;          // width of each of I and Q
   localparam int SMP_W = 2 * IQ_W;    // packed sample: [31:16] I, [15:0] Q

   typedef enum logic [1:0] {
      CYC_IDLE   = 2'd0,
      CYC_ACTIVE = 2'd1,
      CYC_DRAIN  = 2'd2
   } cyc_state_e;

   // True for subcarriers that carry payload: inside the active band, not DC,
   // and not on the pilot grid anchored at glo.
   function automatic logic is_data_sc(input int k, input int nsc, input int glo,
                                       input int ghi, input int psp);
      logic in_band;
      logic is_dc;
      logic is_pilot;
      in_band  = (k >= glo) && (k <= ghi);
      is_dc    = (k == nsc / 2);
      is_pilot = ((k - glo) % psp) == 0;
      return in_band && !is_dc && !is_pilot;
   endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// rtl/wb_skid_fifo.sv - 2-entry registered FIFO for strobe/ack handshakes
//
// Purpose: two-deep buffer with no bypass path; data written at edge n is
//          visible on dat_o from cycle n+1. A push and a pop may share a cycle
//          even when full, so a steady stream sustains one beat per clock.
// Ports:   clk, rst    - clock, synchronous active-high reset
//          push_i      - write dat_i (ignored when full and not popping)
//          dat_i       - write data
//          pop_i       - drop head entry (ignored when empty)
//          dat_o       - head entry
//          empty_o     - no entries held
//          full_o      - both entries held
module wb_skid_fifo #(
   parameter int W = 32
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] dat_i,
   input  logic         pop_i,
   output logic [W-1:0] dat_o,
   output logic         empty_o,
   output logic         full_o
);

   logic [W-1:0] mem_q [2];
   logic         rd_q, rd_d;
   logic         wr_q, wr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         do_push, do_pop;

   assign empty_o = (cnt_q == 2'd0);
   assign full_o  = (cnt_q == 2'd2);
   assign dat_o   = mem_q[rd_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (do_pop)  rd_d = ~rd_q;
      if (do_push) wr_d = ~wr_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_push) mem_q[wr_q] <= dat_i;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pilots_remove.sv
// rtl/pilots_remove.sv - drop guard, DC and pilot subcarriers from FFT output
//
// Purpose: counts subcarriers of each symbol arriving on the upstream strobe/ack
//          port, discards guard-band, DC and pilot beats, and forwards data
//          subcarriers unchanged through a 2-entry FIFO to the downstream port.
//          Frame boundaries follow cyc_i; a frame ending mid-symbol pulses
//          frm_err_o while already-buffered data still drains.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          dat_i, we_i, stb_i, cyc_i - upstream sample and handshake
//          ack_o                    - upstream beat accepted (combinational)
//          dat_o, we_o, stb_o, cyc_o - downstream sample and handshake
//          ack_i                    - downstream accepted head beat
//          frm_err_o                - one-cycle pulse: frame ended mid-symbol
module pilots_remove
   import ofdm_pkg::*;
#(
   parameter int NSC = NSC_DEF,
   parameter int GLO = GLO_DEF,
   parameter int GHI = GHI_DEF,
   parameter int PSP = PSP_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [SMP_W-1:0] dat_i,
   input  logic             we_i,
   input  logic             stb_i,
   input  logic             cyc_i,
   output logic             ack_o,
   output logic [SMP_W-1:0] dat_o,
   output logic             we_o,
   output logic             stb_o,
   output logic             cyc_o,
   input  logic             ack_i,
   output logic             frm_err_o
);

   localparam int KW = $clog2(NSC);

   cyc_state_e       state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic             frm_err_q, frm_err_d;

   logic             beat;
   logic             keep;
   logic             pop;
   logic             room;
   logic             acc;
   logic             push;
   logic             fifo_empty;
   logic             fifo_full;
   logic [SMP_W-1:0] head;

   assign beat = stb_i & cyc_i & we_i;
   assign keep = is_data_sc(int'(k_q), NSC, GLO, GHI, PSP);

   // Outputs are gated by rst so they read 0 during the reset cycle itself,
   // not only after the first reset edge.
   assign stb_o     = ~rst & ~fifo_empty;
   assign we_o      = stb_o;
   assign dat_o     = rst ? '0 : head;
   assign frm_err_o = ~rst & frm_err_q;
   assign cyc_o     = ~rst & ((state_q == CYC_ACTIVE) |
                              ((state_q == CYC_DRAIN) & ~fifo_empty));

   // A full FIFO still has room this cycle if its head leaves; discarded beats
   // never need room, so the guard band streams even while downstream stalls.
   assign pop   = stb_o & ack_i;
   assign room  = ~fifo_full | pop;
   assign acc   = ~rst & beat & (~keep | room);
   assign ack_o = acc;
   assign push  = acc & keep;

   wb_skid_fifo #(
      .W (SMP_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .dat_i   (dat_i),
      .pop_i   (pop),
      .dat_o   (head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   always_comb begin
      k_d = k_q;
      if (!cyc_i) begin
         k_d = '0;
      end else if (acc) begin
         k_d = (k_q == KW'(NSC - 1)) ? '0 : k_q + KW'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      frm_err_d = 1'b0;
      case (state_q)
         CYC_IDLE: begin
            if (acc) state_d = CYC_ACTIVE;
         end
         CYC_ACTIVE: begin
            if (!cyc_i) begin
               state_d   = CYC_DRAIN;
               frm_err_d = (k_q != '0);
            end
         end
         CYC_DRAIN: begin
            // A new frame may already be streaming once the buffer empties.
            if (fifo_empty) state_d = acc ? CYC_ACTIVE : CYC_IDLE;
         end
         default: state_d = CYC_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CYC_IDLE;
         k_q       <= '0;
         frm_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         frm_err_q <= frm_err_d;
      end
   end

endmodule
